maj_pca_score_seq: RTL

MAJ_PCA_SCORE_SEQ -- requirements
Module: maj_pca_score_seq

---
 rtl/maj_pca_score_seq_if.sv | 34 +++
 rtl/maj_pca_score_seq.sv | 106 ++++++++++
 2 files changed

// File: rtl/maj_pca_score_seq_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// maj_pca_score_seq_if : control, pair-input and score handshake bundle  (rev 1.0)
// ------------------------------------------------------------------------
interface maj_pca_score_seq_if #(
  parameter int MAJ_PC_NUM = 2,
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 2*DATA_W + $clog2(MAJ_PC_NUM+1)
);
  localparam int CNT_W = $clog2(MAJ_PC_NUM+1);

  logic                     start;
  logic                     abort;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_eigen;
  logic signed [DATA_W-1:0] in_pc;
  logic                     busy;
  logic [CNT_W-1:0]         pair_cnt;
  logic                     score_valid;
  logic                     score_ready;
  logic signed [ACC_W-1:0]  score;

  modport master (
    output start, abort, in_valid, in_eigen, in_pc, score_ready,
    input  in_ready, busy, pair_cnt, score_valid, score
  );

  modport slave (
    input  start, abort, in_valid, in_eigen, in_pc, score_ready,
    output in_ready, busy, pair_cnt, score_valid, score
  );
endinterface
`default_nettype wire

// File: rtl/maj_pca_score_seq.sv
`default_nettype none
// ------------------------------------------------------------------------
// maj_pca_score_seq : accumulates MAJ_PC_NUM eigenvalue*PC products into a score  (rev 1.0)
// ------------------------------------------------------------------------
module maj_pca_score_seq #(
  parameter int MAJ_PC_NUM = 2,
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 2*DATA_W + $clog2(MAJ_PC_NUM+1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  maj_pca_score_seq_if.slave bus
);
  localparam int CNT_W  = $clog2(MAJ_PC_NUM+1);
  localparam int PROD_W = 2*DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] score_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    score_valid_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     accept;
  logic                     last_pair;

  // Single shared multiplier; ACC_W always exceeds PROD_W so the sign extension is never empty.
  assign prod      = bus.in_eigen * bus.in_pc;
  assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_d     = acc_q + prod_ext;
  assign accept    = bus.in_valid && in_ready_q;
  assign last_pair = (cnt_q == CNT_W'(MAJ_PC_NUM-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      score_q       <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      score_valid_q <= 1'b0;
    end else if (bus.abort) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      score_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_pair) begin
              state_q       <= S_DONE;
              score_q       <= acc_d;
              score_valid_q <= 1'b1;
              in_ready_q    <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.score_ready) begin
            state_q       <= S_IDLE;
            score_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          in_ready_q    <= 1'b0;
          busy_q        <= 1'b0;
          score_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.pair_cnt    = cnt_q;
  assign bus.score_valid = score_valid_q;
  assign bus.score       = score_q;
endmodule
`default_nettype wire
